sha256_req_arbiter: RTL
=======================

Name: sha256_req_arbiter

Overview:
- Shares one single-block SHA-256 engine (sha_start/sha_done, 14 message words, byte size 0..55) among NUM_REQ requesters.
- Per requester: message capture via valid/ready, round-robin grant, one-cycle engine start pulse, hash capture and a held response.
- Adds size checking and a watchdog so a bad request or a hung engine cannot lock out the other requesters.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 127, maximum cycles in WAIT before an error response; must exceed the engine latency of 80 cycles.
- MAX_BYTES, 55, largest legal message size in bytes.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_ready  out  NUM_REQ  request accepted; one-hot or zero
- req_msg  in  NUM_REQ*448  per-requester message; slice i = [448*i +: 448]; word0 in MSBs
- req_size  in  NUM_REQ*6  per-requester message length in bytes
- rsp_valid  out  NUM_REQ  response pending; one-hot or zero
- rsp_ready  in  NUM_REQ  requester takes the response
- rsp_hash  out  256  digest, H0 in MSBs; shared by all requesters
- rsp_err  out  1  1 = size error or timeout; rsp_hash = 0
- eng_start  out  1  engine start pulse
- eng_msg  out  448  drives engine rw0..rw13
- eng_size  out  6  drives engine size
- eng_done  in  1  engine done pulse
- eng_hash  in  256  engine hash_a..hash_h concatenated
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_hash=0, rsp_err=0, eng_start=0, eng_msg=0, eng_size=0, busy=0. FSM=IDLE, rr_ptr=0, timer=0.
- Reset is asynchronous and may occur mid-operation. All state returns to reset values and an in-flight request is lost. The engine shares rst_n.
- FSM states: IDLE, GRANT, LAUNCH, WAIT, RESP.
- IDLE: if any req_valid, go to GRANT.
- GRANT:
  - Pick the first requester with req_valid set, searching from rr_ptr upward with wrap-around.
  - Assert req_ready for exactly that requester for this one cycle.
  - Latch its req_msg and req_size into eng_msg and eng_size; latch grant index g.
  - Set rr_ptr = g+1 mod NUM_REQ.
  - If the latched size > MAX_BYTES: go to RESP with rsp_err=1 and rsp_hash=0; the engine is not started.
  - Otherwise go to LAUNCH.
  - If req_valid has dropped by this cycle: no handshake, return to IDLE.
- LAUNCH: eng_start=1 for exactly one cycle; clear timer; go to WAIT. eng_msg and eng_size stay stable from GRANT until the next grant.
- WAIT: timer increments every cycle.
  - eng_done=1: register eng_hash into rsp_hash, rsp_err=0, go to RESP.
  - timer reaches TIMEOUT_CYCLES first: rsp_err=1, rsp_hash=0, go to RESP.
  - eng_done in the same cycle as the timeout: done wins.
- RESP: rsp_valid[g] held high, with rsp_hash and rsp_err held stable, until rsp_ready[g]=1. On that handshake, clear rsp_valid and return to IDLE.
- Spurious eng_done (any state other than WAIT, including a late done after a timeout) is ignored and does not alter rsp_hash.
- Throughput: at most one outstanding request. Minimum eng_done to next eng_start is 3 cycles (RESP, IDLE, GRANT), which satisfies the engine's one-cycle post-done clear.
- Latency: eng_start is 1 cycle after the accept cycle. rsp_valid is 1 cycle after eng_done, roughly 82 cycles after accept.
- Fairness: rr_ptr advances only on a completed grant. A requester holding req_valid waits at most NUM_REQ-1 services.
- No arithmetic beyond the timer: width clog2(TIMEOUT_CYCLES+1), saturating.

Decomposition:
- Shared package sha256_pkg:
  - FSM state enum.
  - MSG_W=448, HASH_W=256, SIZE_W=6.
  - SHA-256 IV constants, shared with the engine wrapper.
- One natural sub-module, rr_arbiter: NUM_REQ request vector plus pointer in, one-hot grant plus valid out. Purely combinational; reused elsewhere.

Test Plan:
- Single request from req 0, size 3, word0=0x61626300 ("abc"): rsp_valid[0] with rsp_hash=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, rsp_err=0, exactly one eng_start.
- Req 2, size 0 (empty message): rsp_hash=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- All 4 requesters valid at once, continuously: grant order 0,1,2,3,0. No rsp_valid overlap. Each hash matches its own message.
- Req 1, size 56: rsp_err=1, rsp_hash=0, no eng_start. The next request proceeds normally.
- Engine model that never asserts done: rsp_err=1 exactly TIMEOUT_CYCLES after eng_start. A late eng_done afterwards is ignored.
- rst_n low during WAIT, then released: all outputs at reset values. A new request gives the correct hash. Holding rsp_ready low for 20 cycles keeps rsp_valid, rsp_hash and rsp_err stable.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 request arbiter and engine wrapper:
// bus widths, FSM state encodings, the SHA-256 initial hash value and
// the message size check.
package sha256_pkg;

    localparam int MSG_W  = 448;
    localparam int HASH_W = 256;
    localparam int SIZE_W = 6;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_GRANT  = 3'd1;
    localparam state_t ST_LAUNCH = 3'd2;
    localparam state_t ST_WAIT   = 3'd3;
    localparam state_t ST_RESP   = 3'd4;

    // H0..H7, H0 in the MSBs
    localparam logic [HASH_W-1:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // A single-block message must leave room for the 0x80 pad byte and the length.
    function automatic logic size_ok(input logic [SIZE_W-1:0] size, input int max_bytes);
        return int'(size) <= max_bytes;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches the request vector upward from
// ptr with wrap-around and returns a one-hot grant plus a valid flag.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid
);

    logic [PTR_W:0] pos;

    // First requester at or after ptr wins
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        pos       = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (PTR_W+1)'(k);
            if (pos >= (PTR_W+1)'(N)) begin
                pos = pos - (PTR_W+1)'(N);
            end
            if (!gnt_valid && req[pos[PTR_W-1:0]]) begin
                gnt[pos[PTR_W-1:0]] = 1'b1;
                gnt_valid           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha256_req_arbiter.sv
// Shares one single-block SHA-256 engine among NUM_REQ requesters.
//
// state  | meaning
// IDLE   | no request in flight, waiting for any req_valid
// GRANT  | round-robin pick, req_ready to the winner, latch message/size
// LAUNCH | one-cycle eng_start pulse, timer cleared
// WAIT   | waiting for eng_done or the watchdog
// RESP   | response held on the granted requester until rsp_ready
module sha256_req_arbiter
    import sha256_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 127,
    parameter int MAX_BYTES      = 55
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*MSG_W-1:0]  req_msg,
    input  logic [NUM_REQ*SIZE_W-1:0] req_size,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [HASH_W-1:0]         rsp_hash,
    output logic                      rsp_err,
    output logic                      eng_start,
    output logic [MSG_W-1:0]          eng_msg,
    output logic [SIZE_W-1:0]         eng_size,
    input  logic                      eng_done,
    input  logic [HASH_W-1:0]         eng_hash,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   next_ptr;
    logic [PTR_W-1:0]   sel_idx;
    logic [NUM_REQ-1:0] gnt_oh;
    logic [NUM_REQ-1:0] gnt_lat;
    logic               gnt_valid;
    logic [MSG_W-1:0]   sel_msg;
    logic [SIZE_W-1:0]  sel_size;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_inc;
    logic               timeout_hit;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .gnt       (gnt_oh),
        .gnt_valid (gnt_valid)
    );

    // Mux the winner's message, size and index out of the flat request buses
    always_comb begin
        sel_msg  = '0;
        sel_size = '0;
        sel_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_oh[i]) begin
                sel_msg  = sel_msg  | req_msg[MSG_W*i +: MSG_W];
                sel_size = sel_size | req_size[SIZE_W*i +: SIZE_W];
                sel_idx  = sel_idx  | PTR_W'(i);
            end
        end
        next_ptr = (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + PTR_W'(1);
    end

    // Saturating watchdog; timer_inc equals the cycles elapsed since the start
    // pulse, so the timeout response lands exactly TIMEOUT_CYCLES after it
    always_comb begin
        timer_inc   = (timer == TMR_W'(TIMEOUT_CYCLES)) ? timer : timer + TMR_W'(1);
        timeout_hit = (timer_inc == TMR_W'(TIMEOUT_CYCLES - 1));
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        req_ready = (state == ST_GRANT) ? gnt_oh : '0;
        busy      = (state != ST_IDLE);
    end

    // Sequencing FSM and its registered datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            gnt_lat   <= '0;
            timer     <= '0;
            eng_start <= 1'b0;
            eng_msg   <= '0;
            eng_size  <= '0;
            rsp_valid <= '0;
            rsp_hash  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (gnt_valid) begin
                        eng_msg  <= sel_msg;
                        eng_size <= sel_size;
                        gnt_lat  <= gnt_oh;
                        rr_ptr   <= next_ptr;
                        if (size_ok(sel_size, MAX_BYTES)) begin
                            eng_start <= 1'b1;
                            state     <= ST_LAUNCH;
                        end else begin
                            rsp_valid <= gnt_oh;
                            rsp_hash  <= '0;
                            rsp_err   <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end else begin
                        // requester withdrew before the handshake
                        state <= ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    timer <= timer_inc;
                    if (eng_done) begin
                        rsp_valid <= gnt_lat;
                        rsp_hash  <= eng_hash;
                        rsp_err   <= 1'b0;
                        state     <= ST_RESP;
                    end else if (timeout_hit) begin
                        rsp_valid <= gnt_lat;
                        rsp_hash  <= '0;
                        rsp_err   <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (|(rsp_valid & rsp_ready)) begin
                        rsp_valid <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
